alt_mem_ddrx_burst_tracking_mc: RTL and testbench

Multi-channel, parametrised successor to the controller's single-channel burst tracker. It keeps one pending-burstcount counter per channel (port/ID stream), credited on accepted write bursts and debited by the data_id_manager when it consumes data. Channels can count whole bursts or beats. Adds saturation with sticky error flags, almost-full and space-available status, and an all-channel total. Sits between the per-channel write-data burst interfaces and the data_id_manager.

---
 rtl/alt_mem_ddrx_burst_tracking_pkg.sv | 27 ++
 rtl/alt_mem_ddrx_burst_track_slice.sv | 61 ++++++
 rtl/alt_mem_ddrx_burst_tracking_mc.sv | 105 ++++++++++
 tb/tb_alt_mem_ddrx_burst_tracking_mc.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_mem_ddrx_burst_tracking_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel burst tracker.
package alt_mem_ddrx_burst_tracking_pkg;

    localparam int BT_MODE_BURST = 0;
    localparam int BT_MODE_BEAT  = 1;

    function automatic int bt_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int bt_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Largest amount one accepted burst can add to a channel counter.
    function automatic int bt_max_inc(input int mode, input int inc_width);
        return (mode == BT_MODE_BEAT) ? ((1 << inc_width) - 1) : 1;
    endfunction

    function automatic int bt_total_width(input int w, input int num_ch);
        return w + bt_max(bt_clog2(num_ch), 1);
    endfunction

endpackage

// File: rtl/alt_mem_ddrx_burst_track_slice.sv
// Single-channel pending-burst counter: net add/sub, saturating clamp,
// sticky error flags and registered almost-full.
module alt_mem_ddrx_burst_track_slice
    import alt_mem_ddrx_burst_tracking_pkg::*;
#(
    parameter int W      = 7,
    parameter int ADD_W  = 1,
    parameter int SUB_W  = 4,
    parameter int THRESH = 96
) (
    input  logic             ctl_clk,
    input  logic             ctl_reset_n,
    input  logic [ADD_W-1:0] add,
    input  logic [SUB_W-1:0] sub,
    input  logic             err_clear,
    output logic [W-1:0]     cnt_q,
    output logic [W-1:0]     cnt_d,
    output logic             almost_full_q,
    output logic             err_overflow_q,
    output logic             err_underflow_q
);

    // Two guard bits above the widest operand keep the net result exact.
    localparam int ARITH_W = bt_max(W, bt_max(ADD_W, SUB_W)) + 2;
    localparam logic signed [ARITH_W-1:0] MAX_S = ARITH_W'((1 << W) - 1);
    localparam logic [W:0] THRESH_C = (W + 1)'(THRESH);

    logic signed [ARITH_W-1:0] sum;
    logic ovf_set;
    logic udf_set;
    logic almost_full_d;
    logic err_overflow_d;
    logic err_underflow_d;

    always_comb begin
        sum             = $signed(ARITH_W'(cnt_q)) + $signed(ARITH_W'(add)) - $signed(ARITH_W'(sub));
        ovf_set         = sum > MAX_S;
        udf_set         = sum[ARITH_W-1];
        cnt_d           = sum[W-1:0];
        if (ovf_set) cnt_d = '1;
        if (udf_set) cnt_d = '0;
        almost_full_d   = {1'b0, cnt_d} >= THRESH_C;
        err_overflow_d  = ovf_set | (err_overflow_q & ~err_clear);
        err_underflow_d = udf_set | (err_underflow_q & ~err_clear);
    end

    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            cnt_q           <= '0;
            almost_full_q   <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            almost_full_q   <= almost_full_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

endmodule

// File: rtl/alt_mem_ddrx_burst_tracking_mc.sv
// Multi-channel burst tracker: consume decode, per-channel saturating counters,
// registered all-channel total and space-available status.
module alt_mem_ddrx_burst_tracking_mc
    import alt_mem_ddrx_burst_tracking_pkg::*;
#(
    parameter int CFG_NUM_CH                    = 4,
    parameter int CFG_CH_ID_WIDTH               = 2,
    parameter int CFG_BURSTCOUNT_TRACKING_WIDTH = 7,
    parameter int CFG_INT_SIZE_WIDTH            = 4,
    parameter int CFG_INC_WIDTH                 = 4,
    parameter int CFG_COUNT_MODE                = BT_MODE_BURST,
    parameter int CFG_ALMOST_FULL_THRESH        = 96,
    localparam int W       = CFG_BURSTCOUNT_TRACKING_WIDTH,
    localparam int TOTAL_W = bt_total_width(CFG_BURSTCOUNT_TRACKING_WIDTH, CFG_NUM_CH)
) (
    input  logic                                ctl_clk,
    input  logic                                ctl_reset_n,
    input  logic [CFG_NUM_CH-1:0]               burst_valid,
    input  logic [CFG_NUM_CH-1:0]               burst_ready,
    input  logic [CFG_NUM_CH*CFG_INC_WIDTH-1:0] burst_inc,
    input  logic                                burst_consumed_valid,
    input  logic [CFG_CH_ID_WIDTH-1:0]          burst_consumed_ch,
    input  logic [CFG_INT_SIZE_WIDTH-1:0]       burst_consumed_burstcount,
    input  logic                                err_clear,
    output logic [CFG_NUM_CH*W-1:0]             burst_pending_burstcount,
    output logic [CFG_NUM_CH*W-1:0]             burst_next_pending_burstcount,
    output logic [TOTAL_W-1:0]                  burst_total_pending,
    output logic [CFG_NUM_CH-1:0]               burst_almost_full,
    output logic [CFG_NUM_CH-1:0]               burst_space_ok,
    output logic [CFG_NUM_CH-1:0]               err_overflow,
    output logic [CFG_NUM_CH-1:0]               err_underflow
);

    localparam int ADD_W = (CFG_COUNT_MODE == BT_MODE_BEAT) ? CFG_INC_WIDTH : 1;
    localparam int SPACE_LIMIT = (1 << W) - 1 - bt_max_inc(CFG_COUNT_MODE, CFG_INC_WIDTH);
    localparam bit SPACE_POSSIBLE = SPACE_LIMIT >= 0;
    localparam logic [W-1:0] SPACE_LIMIT_C = SPACE_POSSIBLE ? W'(SPACE_LIMIT) : '0;

    logic [CFG_NUM_CH-1:0] consume_sel;
    logic [W-1:0]          cnt_next [CFG_NUM_CH];
    logic [TOTAL_W-1:0]    total_d;
    logic [TOTAL_W-1:0]    total_q;

    // Channel IDs at or above CFG_NUM_CH select nothing, so such consumes drop silently.
    always_comb begin
        consume_sel = '0;
        for (int c = 0; c < CFG_NUM_CH; c++)
            consume_sel[c] = burst_consumed_valid && (burst_consumed_ch == CFG_CH_ID_WIDTH'(c));
    end

    if (CFG_COUNT_MODE != BT_MODE_BEAT) begin : g_inc_unused
        logic unused_burst_inc;
        assign unused_burst_inc = ^burst_inc;
    end

    for (genvar c = 0; c < CFG_NUM_CH; c++) begin : g_ch
        logic                          accept;
        logic [ADD_W-1:0]              add;
        logic [CFG_INT_SIZE_WIDTH-1:0] sub;

        assign accept = burst_valid[c] & burst_ready[c];
        if (CFG_COUNT_MODE == BT_MODE_BEAT) begin : g_beat
            assign add = accept ? burst_inc[c*CFG_INC_WIDTH +: CFG_INC_WIDTH] : '0;
        end else begin : g_burst
            assign add = ADD_W'(accept);
        end
        assign sub = consume_sel[c] ? burst_consumed_burstcount : '0;

        alt_mem_ddrx_burst_track_slice #(
            .W      (W),
            .ADD_W  (ADD_W),
            .SUB_W  (CFG_INT_SIZE_WIDTH),
            .THRESH (CFG_ALMOST_FULL_THRESH)
        ) u_slice (
            .ctl_clk         (ctl_clk),
            .ctl_reset_n     (ctl_reset_n),
            .add             (add),
            .sub             (sub),
            .err_clear       (err_clear),
            .cnt_q           (burst_pending_burstcount[c*W +: W]),
            .cnt_d           (cnt_next[c]),
            .almost_full_q   (burst_almost_full[c]),
            .err_overflow_q  (err_overflow[c]),
            .err_underflow_q (err_underflow[c])
        );

        assign burst_next_pending_burstcount[c*W +: W] = cnt_next[c];
        // Registered count only, so ready logic built on this cannot loop.
        assign burst_space_ok[c] = SPACE_POSSIBLE && (burst_pending_burstcount[c*W +: W] <= SPACE_LIMIT_C);
    end

    always_comb begin
        total_d = '0;
        for (int c = 0; c < CFG_NUM_CH; c++)
            total_d = total_d + TOTAL_W'(cnt_next[c]);
    end

    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) total_q <= '0;
        else              total_q <= total_d;
    end

    assign burst_total_pending = total_q;

endmodule

// File: tb/tb_alt_mem_ddrx_burst_tracking_mc.sv
// Bench: a burst-counting 4-channel instance and a beat-counting 3-channel instance
// share one stimulus stream and are checked against an integer reference model.
module tb_alt_mem_ddrx_burst_tracking_mc;

    logic        clk;
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [15:0] inc;
    logic        cv;
    logic [1:0]  cch;
    logic [3:0]  cbc;
    logic        clr;

    logic [27:0] pend0, next0;
    logic [8:0]  tot0;
    logic [3:0]  af0, sok0, ovf0, udf0;
    logic [20:0] pend1, next1;
    logic [8:0]  tot1;
    logic [2:0]  af1, sok1, ovf1, udf1;

    int n_cmp = 0;
    int n_err = 0;

    int NCH  [2] = '{4, 3};
    int MODE [2] = '{0, 1};
    int m_cnt [2][4];
    int m_nxt [2][4];
    bit m_so  [2][4];
    bit m_su  [2][4];
    bit m_ovf [2][4];
    bit m_udf [2][4];
    bit m_af  [2][4];

    alt_mem_ddrx_burst_tracking_mc u_dut0 (
        .ctl_clk                       (clk),
        .ctl_reset_n                   (rst_n),
        .burst_valid                   (valid),
        .burst_ready                   (ready),
        .burst_inc                     (inc),
        .burst_consumed_valid          (cv),
        .burst_consumed_ch             (cch),
        .burst_consumed_burstcount     (cbc),
        .err_clear                     (clr),
        .burst_pending_burstcount      (pend0),
        .burst_next_pending_burstcount (next0),
        .burst_total_pending           (tot0),
        .burst_almost_full             (af0),
        .burst_space_ok                (sok0),
        .err_overflow                  (ovf0),
        .err_underflow                 (udf0)
    );

    alt_mem_ddrx_burst_tracking_mc #(
        .CFG_NUM_CH     (3),
        .CFG_COUNT_MODE (1)
    ) u_dut1 (
        .ctl_clk                       (clk),
        .ctl_reset_n                   (rst_n),
        .burst_valid                   (valid[2:0]),
        .burst_ready                   (ready[2:0]),
        .burst_inc                     (inc[11:0]),
        .burst_consumed_valid          (cv),
        .burst_consumed_ch             (cch),
        .burst_consumed_burstcount     (cbc),
        .err_clear                     (clr),
        .burst_pending_burstcount      (pend1),
        .burst_next_pending_burstcount (next1),
        .burst_total_pending           (tot1),
        .burst_almost_full             (af1),
        .burst_space_ok                (sok1),
        .err_overflow                  (ovf1),
        .err_underflow                 (udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        valid = '0; ready = '0; inc = '0;
        cv = 1'b0; cch = '0; cbc = '0; clr = 1'b0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                m_cnt[d][c] = 0; m_ovf[d][c] = 0; m_udf[d][c] = 0; m_af[d][c] = 0;
            end
    endtask

    task automatic model_next();
        int add, sub, t;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH[d]; c++) begin
                add = 0;
                if (valid[c] && ready[c]) add = (MODE[d] == 1) ? int'(inc[c*4 +: 4]) : 1;
                sub = (cv && int'(cch) == c) ? int'(cbc) : 0;
                t = m_cnt[d][c] + add - sub;
                m_so[d][c]  = t > 127;
                m_su[d][c]  = t < 0;
                m_nxt[d][c] = (t > 127) ? 127 : ((t < 0) ? 0 : t);
            end
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH[d]; c++) begin
                m_cnt[d][c] = m_nxt[d][c];
                m_af[d][c]  = m_nxt[d][c] >= 96;
                m_ovf[d][c] = m_so[d][c] | (m_ovf[d][c] & ~clr);
                m_udf[d][c] = m_su[d][c] | (m_udf[d][c] & ~clr);
            end
    endtask

    task automatic check_all();
        logic [6:0] p, n;
        logic a, s, o, u;
        int sum, lim;
        for (int d = 0; d < 2; d++) begin
            sum = 0;
            lim = (MODE[d] == 1) ? 112 : 126;
            for (int c = 0; c < NCH[d]; c++) begin
                if (d == 0) begin
                    p = pend0[c*7 +: 7]; n = next0[c*7 +: 7];
                    a = af0[c]; s = sok0[c]; o = ovf0[c]; u = udf0[c];
                end else begin
                    p = pend1[c*7 +: 7]; n = next1[c*7 +: 7];
                    a = af1[c]; s = sok1[c]; o = ovf1[c]; u = udf1[c];
                end
                chk($sformatf("d%0d_pend%0d", d, c), 64'(p), 64'(m_cnt[d][c]));
                chk($sformatf("d%0d_next%0d", d, c), 64'(n), 64'(m_nxt[d][c]));
                chk($sformatf("d%0d_af%0d", d, c), 64'(a), 64'(m_af[d][c]));
                chk($sformatf("d%0d_spok%0d", d, c), 64'(s), 64'(m_cnt[d][c] <= lim));
                chk($sformatf("d%0d_ovf%0d", d, c), 64'(o), 64'(m_ovf[d][c]));
                chk($sformatf("d%0d_udf%0d", d, c), 64'(u), 64'(m_udf[d][c]));
                sum += m_cnt[d][c];
            end
            chk($sformatf("d%0d_total", d), (d == 0) ? 64'(tot0) : 64'(tot1), 64'(sum));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_next();
        check_all();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pend0"}, 64'(pend0), 64'd0);
        chk({tag, "_pend1"}, 64'(pend1), 64'd0);
        chk({tag, "_tot0"},  64'(tot0),  64'd0);
        chk({tag, "_tot1"},  64'(tot1),  64'd0);
        chk({tag, "_af"},    64'({af0, af1}), 64'd0);
        chk({tag, "_err"},   64'({ovf0, udf0, ovf1, udf1}), 64'd0);
        chk({tag, "_spok0"}, 64'(sok0), 64'hF);
        chk({tag, "_spok1"}, 64'(sok1), 64'h7);
    endtask

    task automatic rand_inputs(input int max_cbc);
        valid = 4'($urandom);
        ready = 4'($urandom);
        inc   = 16'($urandom);
        cv    = ($urandom_range(0, 3) == 0);
        cch   = 2'($urandom_range(0, 3));
        cbc   = 4'($urandom_range(0, max_cbc));
        clr   = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #12;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three accepts on ch0, then consume 2.
        idle(); valid[0] = 1'b1; ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("seq_ch0_three", 64'(pend0[6:0]), 64'd3);
        idle(); cv = 1'b1; cch = 2'd0; cbc = 4'd2;
        cycle();
        chk("seq_ch0_consume", 64'(pend0[6:0]), 64'd1);
        idle(); cycle();

        // ch2 to 5, then accept and consume 3 in one cycle.
        idle(); valid[2] = 1'b1; ready[2] = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        cv = 1'b1; cch = 2'd2; cbc = 4'd3;
        cycle();
        chk("same_cycle_ch2", 64'(pend0[20:14]), 64'd3);
        chk("same_cycle_noerr", 64'(udf0[2] | ovf0[2]), 64'd0);

        // Beat mode: 9 x 15 on ch1 saturates at 127.
        idle(); valid[1] = 1'b1; ready[1] = 1'b1; inc[7:4] = 4'hF;
        for (int i = 0; i < 9; i++) cycle();
        chk("sat_ch1", 64'(pend1[13:7]), 64'd127);
        chk("sat_ovf", 64'(ovf1[1]), 64'd1);
        chk("sat_spok", 64'(sok1[1]), 64'd0);
        idle();
        for (int i = 0; i < 3; i++) cycle();
        chk("ovf_sticky", 64'(ovf1[1]), 64'd1);
        clr = 1'b1; cycle(); idle();
        chk("ovf_cleared", 64'(ovf1[1]), 64'd0);

        // Underflow on ch3; clear coinciding with a new underflow keeps the flag.
        idle(); valid[3] = 1'b1; ready[3] = 1'b1;
        for (int i = 0; i < 2; i++) cycle();
        idle(); cv = 1'b1; cch = 2'd3; cbc = 4'd5;
        cycle();
        chk("udf_ch3_cnt", 64'(pend0[27:21]), 64'd0);
        chk("udf_ch3_flag", 64'(udf0[3]), 64'd1);
        cbc = 4'd1; clr = 1'b1;
        cycle();
        chk("udf_set_wins", 64'(udf0[3]), 64'd1);
        chk("oor_ch_noerr", 64'({ovf1, udf1}), 64'd0);
        idle(); cycle();

        // Almost-full crossing 95 -> 96 -> 95 on beat-mode ch2.
        idle(); valid[2] = 1'b1; ready[2] = 1'b1; inc[11:8] = 4'hF;
        for (int i = 0; i < 6; i++) cycle();
        inc[11:8] = 4'd5; cycle();
        chk("af_95_cnt", 64'(pend1[20:14]), 64'd95);
        chk("af_95_flag", 64'(af1[2]), 64'd0);
        inc[11:8] = 4'd1; cycle();
        chk("af_96_cnt", 64'(pend1[20:14]), 64'd96);
        chk("af_96_flag", 64'(af1[2]), 64'd1);
        idle(); cv = 1'b1; cch = 2'd2; cbc = 4'd1;
        cycle();
        chk("af_fall_flag", 64'(af1[2]), 64'd0);
        idle(); cycle();

        // Random traffic: light consumes first so counters climb, then heavy.
        for (int i = 0; i < 300; i++) begin rand_inputs(2);  cycle(); end
        for (int i = 0; i < 300; i++) begin rand_inputs(15); cycle(); end

        // Async reset in the middle of a cycle with traffic still applied.
        rand_inputs(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin rand_inputs(3); cycle(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
